// File: rtl/socket_arb_pkg.sv
// Shared types and helpers for the socket round-robin arbiter.
// Optional full-priority arbitration is enabled with SOCKET_ARB_FULL_PRIO_EN.
package socket_arb_pkg;

    typedef enum logic {IDLE, GRANT} arb_state_t;

    localparam int MAX_SOCK  = 16;
    localparam int MAX_IDX_W = 4;

    // Index width for n sockets, never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

    typedef struct packed {
        logic                 found;
        logic [MAX_IDX_W-1:0] idx;
    } rr_pick_t;

    // First requester strictly after ptr, wrapping modulo n.
    function automatic rr_pick_t rr_pick(input logic [MAX_SOCK-1:0]  req,
                                         input logic [MAX_IDX_W-1:0] ptr,
                                         input int                   n);
        rr_pick_t res;
        int       j;
        res = '0;
        for (int k = 1; k <= MAX_SOCK; k++) begin
            j = int'(ptr) + k;
            if (j >= n) j = j - n;
            if (k <= n && !res.found && req[j[MAX_IDX_W-1:0]]) begin
                res.found = 1'b1;
                res.idx   = j[MAX_IDX_W-1:0];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/socket_rr_arbiter_if.sv
// Socket-side and module-side handshake bundle of the arbiter.
// The arbiter connects through the slave modport, the environment through master.
interface socket_rr_arbiter_if #(
    parameter int N_SOCK     = 4,
    parameter int DATA_WIDTH = 8
);
    localparam int IDX_W = socket_arb_pkg::idx_width(N_SOCK);

    logic [N_SOCK*DATA_WIDTH-1:0] s_data;
    logic [N_SOCK-1:0]            s_dv;
    logic [N_SOCK-1:0]            s_full;
    logic [N_SOCK-1:0]            s_rd_en;
    logic [DATA_WIDTH-1:0]        m_data;
    logic                         m_dv;
    logic                         m_full;
    logic                         m_rd_en;
    logic [IDX_W-1:0]             grant_idx;
    logic                         grant_vld;

    modport slave (
        input  s_data, s_dv, s_full, m_rd_en,
        output s_rd_en, m_data, m_dv, m_full, grant_idx, grant_vld
    );

    modport master (
        output s_data, s_dv, s_full, m_rd_en,
        input  s_rd_en, m_data, m_dv, m_full, grant_idx, grant_vld
    );

endinterface

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first set bit of req after ptr, wrapping.
module rr_picker
    import socket_arb_pkg::*;
#(
    parameter int N_SOCK = 4,
    parameter int IDX_W  = idx_width(N_SOCK)
) (
    input  logic [N_SOCK-1:0] req,
    input  logic [IDX_W-1:0]  ptr,
    output logic [IDX_W-1:0]  idx,
    output logic              found
);

    logic [MAX_SOCK-1:0]  req_ext;
    logic [MAX_IDX_W-1:0] ptr_ext;
    rr_pick_t             pick;
    logic                 unused_idx_bits;

    always_comb begin
        req_ext              = '0;
        req_ext[N_SOCK-1:0]  = req;
        ptr_ext              = '0;
        ptr_ext[IDX_W-1:0]   = ptr;
        pick                 = rr_pick(req_ext, ptr_ext, N_SOCK);
    end

    assign idx             = pick.idx[IDX_W-1:0];
    assign found           = pick.found;
    assign unused_idx_bits = ^pick.idx;

endmodule

// File: rtl/socket_rr_arbiter.sv
// Round-robin arbiter sharing one downstream module between N_SOCK sockets,
// with bounded bursts per grant. SOCKET_ARB_FULL_PRIO_EN favours full sockets.
module socket_rr_arbiter
    import socket_arb_pkg::*;
#(
    parameter int N_SOCK     = 4,
    parameter int DATA_WIDTH = 8,
    parameter int BURST_MAX  = 4
) (
    input logic                 clk,
    input logic                 rst,
    socket_rr_arbiter_if.slave  bus
);

    localparam int IDX_W = idx_width(N_SOCK);
    localparam int CNT_W = 8;
    localparam logic [CNT_W-1:0] BURST_LAST = CNT_W'(BURST_MAX - 1);
    localparam logic [IDX_W-1:0] PTR_RST    = IDX_W'(N_SOCK - 1);

    arb_state_t        state, state_nxt;
    logic [IDX_W-1:0]  grant_idx_q, grant_idx_nxt;
    logic [IDX_W-1:0]  rr_ptr, rr_ptr_nxt;
    logic [CNT_W-1:0]  burst_cnt, burst_cnt_nxt;

    logic [IDX_W-1:0]  all_idx, win_idx;
    logic              all_found, win_found;
    logic              prio_cut;

    logic [DATA_WIDTH-1:0] s_word [N_SOCK];
    logic                  g_dv, g_full;
    logic [DATA_WIDTH-1:0] g_data;

    logic [N_SOCK-1:0]     s_rd_en;
    logic [DATA_WIDTH-1:0] m_data;
    logic                  m_dv, m_full;
    logic                  release_grant;

    for (genvar i = 0; i < N_SOCK; i++) begin : g_unpack
        assign s_word[i] = bus.s_data[i*DATA_WIDTH +: DATA_WIDTH];
    end

    assign g_dv   = bus.s_dv[grant_idx_q];
    assign g_full = bus.s_full[grant_idx_q];
    assign g_data = s_word[grant_idx_q];

    rr_picker #(.N_SOCK(N_SOCK), .IDX_W(IDX_W)) u_pick_all (
        .req   (bus.s_dv),
        .ptr   (rr_ptr),
        .idx   (all_idx),
        .found (all_found)
    );

`ifdef SOCKET_ARB_FULL_PRIO_EN
    logic [IDX_W-1:0]  full_idx;
    logic              full_found;
    logic [N_SOCK-1:0] g_onehot;

    rr_picker #(.N_SOCK(N_SOCK), .IDX_W(IDX_W)) u_pick_full (
        .req   (bus.s_dv & bus.s_full),
        .ptr   (rr_ptr),
        .idx   (full_idx),
        .found (full_found)
    );

    always_comb begin
        g_onehot              = '0;
        g_onehot[grant_idx_q] = 1'b1;
    end

    // A full requester elsewhere cuts a non-full grant short after its transfer.
    assign prio_cut  = ~g_full & (|(bus.s_full & ~g_onehot));
    assign win_idx   = full_found ? full_idx : all_idx;
    assign win_found = all_found;
`else
    assign prio_cut  = 1'b0;
    assign win_idx   = all_idx;
    assign win_found = all_found;
`endif

    // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        state_nxt     = state;
        grant_idx_nxt = grant_idx_q;
        rr_ptr_nxt    = rr_ptr;
        burst_cnt_nxt = burst_cnt;
        s_rd_en       = '0;
        m_data        = '0;
        m_dv          = 1'b0;
        m_full        = 1'b0;
        release_grant = 1'b0;

        unique case (state)
            IDLE: begin
                if (win_found) begin
                    state_nxt     = GRANT;
                    grant_idx_nxt = win_idx;
                    burst_cnt_nxt = '0;
                end
            end
            GRANT: begin
                m_data               = g_data;
                m_dv                 = g_dv;
                m_full               = g_full;
                s_rd_en[grant_idx_q] = bus.m_rd_en & g_dv;

                if (!g_dv) begin
                    release_grant = 1'b1;
                end else if (bus.m_rd_en) begin
                    release_grant = (burst_cnt == BURST_LAST) | prio_cut;
                    burst_cnt_nxt = burst_cnt + 1'b1;
                end

                if (release_grant) begin
                    state_nxt     = IDLE;
                    rr_ptr_nxt    = grant_idx_q;
                    burst_cnt_nxt = '0;
                end
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            grant_idx_q <= '0;
            rr_ptr      <= PTR_RST;
            burst_cnt   <= '0;
        end else begin
            state       <= state_nxt;
            grant_idx_q <= grant_idx_nxt;
            rr_ptr      <= rr_ptr_nxt;
            burst_cnt   <= burst_cnt_nxt;
        end
    end

    assign bus.s_rd_en   = s_rd_en;
    assign bus.m_data    = m_data;
    assign bus.m_dv      = m_dv;
    assign bus.m_full    = m_full;
    assign bus.grant_idx = grant_idx_q;
    assign bus.grant_vld = (state == GRANT);

endmodule
